// File: rtl/alu_iter.sv
// Clocked ALU: simple ops register at the accept edge (latency 1); MUL/DIV iterate WIDTH steps (latency WIDTH+1).
// in_ready is high only in IDLE; in_valid presented during CALC is ignored and must be held upstream.
module alu_iter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       OP,
    output logic             out_valid,
    output logic [WIDTH-1:0] C,
    output logic             Cout,
    output logic             Zero,
    output logic             div_zero,
    output logic             op_err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_ORR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_TCP  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ID   = 4'd8;
    localparam logic [3:0] OP_LHI  = 4'd9;
    localparam logic [3:0] OP_MULL = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIVU = 4'd12;
    localparam logic [3:0] OP_REMU = 4'd13;

    typedef enum logic {S_IDLE, S_CALC} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;
    logic               dz_q, dz_d;
    logic               oe_q, oe_d;
    logic               ov_q, ov_d;

    logic [WIDTH:0]     add_sum, sub_dif;
    logic [WIDTH-1:0]   simple_c;
    logic               simple_cout, simple_err;
    logic               in_is_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc, mul_lo;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_sub, div_acc, div_lo;
    logic               div_geq, is_div, b_zero;

    assign add_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign sub_dif = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
    assign in_is_iter = (OP == OP_MULL) || (OP == OP_MULH) || (OP == OP_DIVU) || (OP == OP_REMU);

    always_comb begin
        simple_c    = '0;
        simple_cout = 1'b0;
        simple_err  = 1'b0;
        case (OP)
            OP_ADD: begin simple_c = add_sum[WIDTH-1:0]; simple_cout = add_sum[WIDTH]; end
            OP_SUB: begin simple_c = sub_dif[WIDTH-1:0]; simple_cout = sub_dif[WIDTH]; end
            OP_AND: simple_c = A & B;
            OP_ORR: simple_c = A | B;
            OP_NOT: simple_c = ~A;
            OP_TCP: simple_c = ~A + WIDTH'(1);
            OP_SHL: simple_c = {A[WIDTH-2:0], 1'b0};
            OP_SHR: simple_c = {A[WIDTH-1], A[WIDTH-1:1]};
            OP_ID:  simple_c = A;
            OP_LHI: simple_c = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: begin simple_c = '0; simple_cout = 1'b1; simple_err = 1'b1; end
        endcase
    end

    // Multiply: {acc, lo} shifts right, adding B into acc when the multiplier LSB is set.
    assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign mul_acc = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Divide: restoring; the remainder after a subtract is below B so WIDTH bits suffice.
    assign div_sh  = {acc_q, lo_q[WIDTH-1]};
    assign div_geq = div_sh >= {1'b0, b_q};
    assign div_sub = div_sh[WIDTH-1:0] - b_q;
    assign div_acc = div_geq ? div_sub : div_sh[WIDTH-1:0];
    assign div_lo  = {lo_q[WIDTH-2:0], div_geq};

    assign is_div = (op_q == OP_DIVU) || (op_q == OP_REMU);
    assign b_zero = (b_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        c_d     = c_q;
        cout_d  = cout_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        oe_d    = oe_q;
        ov_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dz_d = 1'b0;
                    if (in_is_iter) begin
                        state_d = S_CALC;
                        cnt_d   = '0;
                        acc_d   = '0;
                        lo_d    = A;
                        a_d     = A;
                        b_d     = B;
                        op_d    = OP;
                        oe_d    = 1'b0;
                    end else begin
                        c_d    = simple_c;
                        cout_d = simple_cout;
                        zero_d = (A == B);
                        oe_d   = simple_err;
                        ov_d   = 1'b1;
                    end
                end
            end
            S_CALC: begin
                acc_d = is_div ? div_acc : mul_acc;
                lo_d  = is_div ? div_lo : mul_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ov_d    = 1'b1;
                    cout_d  = 1'b0;
                    zero_d  = (a_q == b_q);
                    dz_d    = is_div && b_zero;
                    case (op_q)
                        OP_MULL: c_d = mul_lo;
                        OP_MULH: c_d = mul_acc;
                        OP_DIVU: c_d = b_zero ? {WIDTH{1'b1}} : div_lo;
                        OP_REMU: c_d = b_zero ? a_q : div_acc;
                        default: c_d = '0;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            oe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            oe_q    <= oe_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = ov_q;
    assign C         = c_q;
    assign Cout      = cout_q;
    assign Zero      = zero_q;
    assign div_zero  = dz_q;
    assign op_err    = oe_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: WIDTH=16 and WIDTH=8 instances checked against a plain-arithmetic reference model.
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, Cin16, out_valid16, Cout16, Zero16, dz16, oe16;
    logic [15:0] A16, B16, C16;
    logic [3:0]  OP16;
    logic        in_valid8, in_ready8, Cin8, out_valid8, Cout8, Zero8, dz8, oe8;
    logic [7:0]  A8, B8, C8;
    logic [3:0]  OP8;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter #(.WIDTH(16), .CNT_W(5)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .A(A16), .B(B16), .Cin(Cin16), .OP(OP16), .out_valid(out_valid16),
        .C(C16), .Cout(Cout16), .Zero(Zero16), .div_zero(dz16), .op_err(oe16));

    alu_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Cin(Cin8), .OP(OP8), .out_valid(out_valid8),
        .C(C8), .Cout(Cout8), .Zero(Zero8), .div_zero(dz8), .op_err(oe8));

    typedef struct packed {
        logic [15:0] c;
        logic        cout, zero, dz, oe;
        logic [31:0] lat;
    } res_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;
        logic [15:0] c;
        logic        cout, zero, dz, oe;
        logic [7:0]  lat;
    } vec_t;

    function automatic res_t model(input int w, input logic [3:0] op,
                                   input logic [15:0] a_in, input logic [15:0] b_in, input logic cin);
        longint a = longint'(a_in);
        longint b = longint'(b_in);
        longint m = (longint'(1) << w) - 1;
        longint s;
        longint r = 0;
        res_t x;
        x = '0;
        x.lat  = 1;
        x.zero = (a == b);
        case (op)
            4'd0: begin s = a + b + longint'(cin); r = s; x.cout = ((s >> w) & 1) != 0; end
            4'd1: begin s = a - b - longint'(cin); r = s; x.cout = ((s >> w) & 1) != 0; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~a;
            4'd5: r = -a;
            4'd6: r = a << 1;
            4'd7: r = (a >> 1) | (a & (longint'(1) << (w - 1)));
            4'd8: r = a;
            4'd9: r = (b & ((longint'(1) << (w / 2)) - 1)) << (w / 2);
            4'd10: begin r = a * b; x.lat = w + 1; end
            4'd11: begin r = (a * b) >> w; x.lat = w + 1; end
            4'd12: begin r = (b == 0) ? m : a / b; x.dz = (b == 0); x.lat = w + 1; end
            4'd13: begin r = (b == 0) ? a : a % b; x.dz = (b == 0); x.lat = w + 1; end
            default: begin r = 0; x.cout = 1'b1; x.oe = 1'b1; end
        endcase
        x.c = 16'(r & m);
        return x;
    endfunction

    // Issue one op on the 16-bit instance and wait (bounded) for its out_valid; lat = -1 on timeout.
    task automatic run_op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, output int lat, output int rdy_low);
        @(negedge clk);
        in_valid16 = 1'b1; OP16 = op; A16 = a; B16 = b; Cin16 = cin;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0; A16 = 16'($urandom); B16 = 16'($urandom); Cin16 = 1'($urandom);
        lat = 1; rdy_low = 0;
        while (!out_valid16 && lat < 40) begin
            if (!in_ready16) rdy_low++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid16) lat = -1;
    endtask

    task automatic run_op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, output int lat, output int rdy_low);
        @(negedge clk);
        in_valid8 = 1'b1; OP8 = op; A8 = a; B8 = b; Cin8 = cin;
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom); Cin8 = 1'($urandom);
        lat = 1; rdy_low = 0;
        while (!out_valid8 && lat < 40) begin
            if (!in_ready8) rdy_low++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid8) lat = -1;
    endtask

    task automatic test_reset;
        logic [6:0] got;
        got = {in_ready16, out_valid16, Cout16, Zero16, dz16, oe16, in_ready8};
        n_checks++;
        if (got !== 7'b1000001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 1000001", got);
        end
        n_checks++;
        if (C16 !== 16'h0000 || C8 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_c: got C16=%h C8=%h want 0", C16, C8);
        end
    endtask

    task automatic test_directed16;
        vec_t tv [11];
        int   lat, rl;
        tv = '{
            '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1},
            '{4'd1,  16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1},
            '{4'd10, 16'h1234, 16'h0010, 1'b0, 16'h2340, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17},
            '{4'd11, 16'h1234, 16'h0010, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd17},
            '{4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 8'd17},
            '{4'd12, 16'd100,  16'd7,    1'b0, 16'd14,   1'b0, 1'b0, 1'b0, 1'b0, 8'd17},
            '{4'd13, 16'd100,  16'd7,    1'b0, 16'd2,    1'b0, 1'b0, 1'b0, 1'b0, 8'd17},
            '{4'd12, 16'h00AB, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17},
            '{4'd13, 16'h00AB, 16'h0000, 1'b0, 16'h00AB, 1'b0, 1'b0, 1'b1, 1'b0, 8'd17},
            '{4'd14, 16'h0001, 16'h0002, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1},
            '{4'd15, 16'h7777, 16'h7777, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1}
        };
        for (int i = 0; i < 11; i++) begin
            run_op16(tv[i].op, tv[i].a, tv[i].b, tv[i].cin, lat, rl);
            n_checks++;
            if (lat !== int'(tv[i].lat)) begin
                n_fail++;
                $display("FAIL dir16_lat[%0d] op=%0d: got %0d want %0d", i, tv[i].op, lat, tv[i].lat);
            end
            n_checks++;
            if (rl !== int'(tv[i].lat) - 1) begin
                n_fail++;
                $display("FAIL dir16_rdy_low[%0d]: got %0d want %0d", i, rl, int'(tv[i].lat) - 1);
            end
            n_checks++;
            if ({C16, Cout16, Zero16, dz16, oe16} !== {tv[i].c, tv[i].cout, tv[i].zero, tv[i].dz, tv[i].oe}) begin
                n_fail++;
                $display("FAIL dir16_res[%0d] op=%0d: got C=%h cout=%b z=%b dz=%b oe=%b want C=%h cout=%b z=%b dz=%b oe=%b",
                         i, tv[i].op, C16, Cout16, Zero16, dz16, oe16,
                         tv[i].c, tv[i].cout, tv[i].zero, tv[i].dz, tv[i].oe);
            end
        end
    endtask

    task automatic test_random16;
        logic [3:0]  op;
        logic [15:0] a, b;
        logic        cin;
        res_t        e;
        int          lat, rl;
        for (int i = 0; i < 40; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = 16'($urandom);
            b   = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
            if ($urandom_range(0, 5) == 0) b = a;
            cin = 1'($urandom);
            e   = model(16, op, a, b, cin);
            run_op16(op, a, b, cin, lat, rl);
            n_checks++;
            if (lat !== int'(e.lat)) begin
                n_fail++;
                $display("FAIL rnd16_lat op=%0d: got %0d want %0d", op, lat, e.lat);
            end
            n_checks++;
            if ({C16, Cout16, Zero16, dz16, oe16} !== {e.c, e.cout, e.zero, e.dz, e.oe}) begin
                n_fail++;
                $display("FAIL rnd16_res op=%0d a=%h b=%h cin=%b: got C=%h cout=%b z=%b dz=%b oe=%b want C=%h cout=%b z=%b dz=%b oe=%b",
                         op, a, b, cin, C16, Cout16, Zero16, dz16, oe16, e.c, e.cout, e.zero, e.dz, e.oe);
            end
        end
    endtask

    task automatic test_reset_mid_calc;
        int lat, rl, seen;
        run_op16(4'd0, 16'h0001, 16'h0001, 1'b0, lat, rl);
        @(negedge clk);
        in_valid16 = 1'b1; OP16 = 4'd12; A16 = 16'd1000; B16 = 16'd7; Cin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({in_ready16, out_valid16} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_mid_hs: got rdy=%b ov=%b want rdy=1 ov=0", in_ready16, out_valid16);
        end
        n_checks++;
        if ({C16, Cout16, Zero16, dz16, oe16} !== 20'h0) begin
            n_fail++;
            $display("FAIL rst_mid_res: got C=%h cout=%b z=%b dz=%b oe=%b want all 0", C16, Cout16, Zero16, dz16, oe16);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid16) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_no_ov: got %0d out_valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        in_valid16 = 1'b1; OP16 = 4'd12; A16 = 16'd9; B16 = 16'd3; Cin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!out_valid16 && lat < 40) begin
            in_valid16 = 1'($urandom); OP16 = 4'd0; A16 = 16'($urandom); B16 = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat !== 17 || !out_valid16 || C16 !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_div: got lat=%0d ov=%b C=%h want lat=17 ov=1 C=0003", lat, out_valid16, C16);
        end
        n_checks++;
        if (in_ready16 !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b want 1", in_ready16);
        end
        in_valid16 = 1'b1; OP16 = 4'd0; A16 = 16'd2; B16 = 16'd2; Cin16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        n_checks++;
        if ({out_valid16, C16, Zero16, dz16} !== {1'b1, 16'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_add: got ov=%b C=%h z=%b dz=%b want ov=1 C=0004 z=1 dz=0", out_valid16, C16, Zero16, dz16);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid16 !== 1'b0 || C16 !== 16'd4) begin
            n_fail++;
            $display("FAIL b2b_hold: got ov=%b C=%h want ov=0 C=0004", out_valid16, C16);
        end
    endtask

    task automatic test_width8;
        logic [3:0] op;
        logic [7:0] a, b;
        logic       cin;
        res_t       e;
        int         lat, rl;
        run_op8(4'd7, 8'h80, 8'h11, 1'b0, lat, rl);
        n_checks++;
        if (lat !== 1 || C8 !== 8'hC0 || Cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL w8_shr: got lat=%0d C=%h cout=%b want lat=1 C=c0 cout=0", lat, C8, Cout8);
        end
        run_op8(4'd9, 8'h33, 8'h0A, 1'b1, lat, rl);
        n_checks++;
        if (lat !== 1 || C8 !== 8'hA0) begin
            n_fail++;
            $display("FAIL w8_lhi: got lat=%0d C=%h want lat=1 C=a0", lat, C8);
        end
        run_op8(4'd11, 8'hFF, 8'hFF, 1'b0, lat, rl);
        n_checks++;
        if (lat !== 9 || rl !== 8 || C8 !== 8'hFE || Zero8 !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_mulh: got lat=%0d rdy_low=%0d C=%h z=%b want lat=9 rdy_low=8 C=fe z=1", lat, rl, C8, Zero8);
        end
        for (int i = 0; i < 30; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = 8'($urandom);
            b   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            cin = 1'($urandom);
            e   = model(8, op, {8'h00, a}, {8'h00, b}, cin);
            run_op8(op, a, b, cin, lat, rl);
            n_checks++;
            if (lat !== int'(e.lat) || {C8, Cout8, Zero8, dz8, oe8} !== {e.c[7:0], e.cout, e.zero, e.dz, e.oe}) begin
                n_fail++;
                $display("FAIL rnd8 op=%0d a=%h b=%h cin=%b: got lat=%0d C=%h cout=%b z=%b dz=%b oe=%b want lat=%0d C=%h cout=%b z=%b dz=%b oe=%b",
                         op, a, b, cin, lat, C8, Cout8, Zero8, dz8, oe8, e.lat, e.c[7:0], e.cout, e.zero, e.dz, e.oe);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid16 = 1'b0; A16 = '0; B16 = '0; Cin16 = 1'b0; OP16 = '0;
        in_valid8  = 1'b0; A8  = '0; B8  = '0; Cin8  = 1'b0; OP8  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_directed16();
        test_random16();
        test_reset_mid_calc();
        test_back_to_back();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
